lsu_ctrl: RTL and testbench

//  Load/store unit between the core's MEM stage and the byte-addressed data memory (word-wide port, combinational read, synchronous write, no byte enables).

---
 rtl/lsu_pkg.sv | 45 ++++
 rtl/lsu_align.sv | 59 +++++
 rtl/lsu_ctrl.sv | 171 +++++++++++++++++
 tb/tb_lsu_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - funct3 access-size codes (LDST_B/H/W/BU/HU)
//   - FSM state encodings (IDLE, WRITE, DONE)
//   - access-width enum and byte-lane masks
//   - helpers that decode a funct3 size into width and signedness
// Undefined size codes (011, 110, 111) decode as a full word.
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        WID_BYTE = 2'd0,
        WID_HALF = 2'd1,
        WID_WORD = 2'd2
    } lsu_width_e;

    localparam logic [31:0] LANE_B_MASK = 32'h0000_00FF;
    localparam logic [31:0] LANE_H_MASK = 32'h0000_FFFF;

    function automatic lsu_width_e size_to_width(input logic [2:0] size);
        lsu_width_e w;
        case (size)
            LDST_B, LDST_BU: w = WID_BYTE;
            LDST_H, LDST_HU: w = WID_HALF;
            default:         w = WID_WORD;
        endcase
        return w;
    endfunction

    function automatic logic size_is_unsigned(input logic [2:0] size);
        return (size == LDST_BU) || (size == LDST_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Combinational lane logic for the load/store unit.
//   size_i        funct3 access size
//   off_i         byte offset within the word (already aligned for H/W)
//   mem_word_i    word read from data memory
//   store_data_i  store data from the core (low byte/half used for SB/SH)
//   load_data_o   extracted and sign/zero-extended load result
//   store_word_o  word to write back (store data merged into mem_word_i)
// -----------------------------------------------------------------------------
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] mem_word_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_word_o
);

    lsu_width_e  width_s;
    logic        uns_s;
    logic [4:0]  shift_s;
    logic [31:0] shifted_s;

    // Lane extraction / extension for loads and read-modify-write merge for stores
    always_comb begin
        width_s   = size_to_width(size_i);
        uns_s     = size_is_unsigned(size_i);
        shift_s   = {off_i, 3'b000};
        shifted_s = mem_word_i >> shift_s;
        case (width_s)
            WID_BYTE: begin
                if (uns_s) begin
                    load_data_o = {24'h000000, shifted_s[7:0]};
                end else begin
                    load_data_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
                end
                store_word_o = (mem_word_i & ~(LANE_B_MASK << shift_s))
                             | ((store_data_i & LANE_B_MASK) << shift_s);
            end
            WID_HALF: begin
                if (uns_s) begin
                    load_data_o = {16'h0000, shifted_s[15:0]};
                end else begin
                    load_data_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
                end
                store_word_o = (mem_word_i & ~(LANE_H_MASK << shift_s))
                             | ((store_data_i & LANE_H_MASK) << shift_s);
            end
            default: begin
                load_data_o  = mem_word_i;
                store_word_o = store_data_i;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl
// Load/store unit between the MEM stage and a word-wide data memory with
// combinational read and synchronous write (no byte enables). Sub-word stores
// are done as read-modify-write. Loads stall one cycle, stores two.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   lsu_req_i/we_i     request, 1=store
//   lsu_size_i         funct3 size code
//   lsu_addr_i         byte address
//   lsu_wd_i           store data
//   lsu_rd_o           registered, extended load result
//   lsu_stall_o        hold the MEM stage
//   lsu_misalign_o     misaligned-access pulse (trap build only)
//   mem_we_o/addr_o/wd_o  data memory write enable, word address, write data
//   mem_rd_i           data memory read word
//
// Build option LSU_MISALIGN_TRAP_EN: misaligned H/W accesses are dropped and
// flagged on lsu_misalign_o. Without it, the offending low address bits are
// cleared and the access proceeds.
// -----------------------------------------------------------------------------
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned DMEM_SIZE_BYTES = 1024
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wd_i,
    output logic [31:0] lsu_rd_o,
    output logic        lsu_stall_o,
    output logic        lsu_misalign_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i
);

    // Word-aligned wrap mask: memory never sees an address above size-4.
    localparam logic [31:0] ADDR_MASK =
        (32'(DMEM_SIZE_BYTES) - 32'd1) & 32'hFFFF_FFFC;

    logic [1:0]  state_q, state_d;
    logic [29:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] rd_q, rd_d;

    lsu_width_e  width_s;
    logic        trap_s;
    logic [31:0] addr_fix_s;
    logic [29:0] word_addr_s;
    logic        stall_s;
    logic        mis_s;
    logic [31:0] load_data_s;
    logic [31:0] store_word_s;

`ifdef LSU_MISALIGN_TRAP_EN
    // Detect misaligned halfword/word accesses; the address is used untouched
    always_comb begin
        width_s    = size_to_width(lsu_size_i);
        addr_fix_s = lsu_addr_i;
        if (width_s == WID_HALF) begin
            trap_s = lsu_addr_i[0];
        end else if (width_s == WID_WORD) begin
            trap_s = (lsu_addr_i[1:0] != 2'b00);
        end else begin
            trap_s = 1'b0;
        end
    end
`else
    // Force natural alignment by clearing the offending low address bits
    always_comb begin
        width_s = size_to_width(lsu_size_i);
        trap_s  = 1'b0;
        case (width_s)
            WID_HALF: addr_fix_s = {lsu_addr_i[31:1], 1'b0};
            WID_WORD: addr_fix_s = {lsu_addr_i[31:2], 2'b00};
            default:  addr_fix_s = lsu_addr_i;
        endcase
    end
`endif

    // Memory address: live request address in IDLE, latched store address later
    always_comb begin
        if (state_q == ST_IDLE) begin
            word_addr_s = addr_fix_s[31:2];
        end else begin
            word_addr_s = addr_q;
        end
    end

    assign mem_addr_o = {word_addr_s, 2'b00} & ADDR_MASK;

    lsu_align u_align (
        .size_i       (lsu_size_i),
        .off_i        (addr_fix_s[1:0]),
        .mem_word_i   (mem_rd_i),
        .store_data_i (lsu_wd_i),
        .load_data_o  (load_data_s),
        .store_word_o (store_word_s)
    );

    // FSM next-state and datapath update
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        stall_s = 1'b0;
        mis_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (lsu_req_i) begin
                    if (trap_s) begin
                        mis_s = 1'b1;
                    end else begin
                        stall_s = 1'b1;
                        if (lsu_we_i) begin
                            addr_d  = addr_fix_s[31:2];
                            wd_d    = store_word_s;
                            state_d = ST_WRITE;
                        end else begin
                            rd_d    = load_data_s;
                            state_d = ST_DONE;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                stall_s = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= 30'h0;
            wd_q    <= 32'h0;
            rd_q    <= 32'h0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
        end
    end

    // Gating with rst_n keeps outputs quiet (and blocks a write) while in reset.
    assign lsu_rd_o       = rd_q;
    assign lsu_stall_o    = stall_s & rst_n;
    assign lsu_misalign_o = mis_s & rst_n;
    assign mem_we_o       = (state_q == ST_WRITE) & rst_n;
    assign mem_wd_o       = wd_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lsu_req_i, lsu_we_i;
    logic [2:0]  lsu_size_i;
    logic [31:0] lsu_addr_i, lsu_wd_i;
    logic [31:0] lsu_rd_o;
    logic        lsu_stall_o, lsu_misalign_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o, mem_wd_o, mem_rd_i;

    always #5 clk = ~clk;

    lsu_ctrl #(.DMEM_SIZE_BYTES(1024)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .lsu_req_i      (lsu_req_i),
        .lsu_we_i       (lsu_we_i),
        .lsu_size_i     (lsu_size_i),
        .lsu_addr_i     (lsu_addr_i),
        .lsu_wd_i       (lsu_wd_i),
        .lsu_rd_o       (lsu_rd_o),
        .lsu_stall_o    (lsu_stall_o),
        .lsu_misalign_o (lsu_misalign_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wd_o       (mem_wd_o),
        .mem_rd_i       (mem_rd_i)
    );

    // Data memory model: 256 words, combinational read, synchronous write
    logic [31:0] mem [0:255];
    assign mem_rd_i = mem[mem_addr_o[9:2]];
    always @(posedge clk) begin
        if (mem_we_o) mem[mem_addr_o[9:2]] <= mem_wd_o;
    end

    localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010,
                           SZ_BU = 3'b100, SZ_HU = 3'b101;

    typedef struct {
        logic [31:0] rd;
        logic [31:0] wd;
        logic [31:0] waddr;
        int          stalls;
        int          writes;
        logic        mis;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          vectors = 0;
    int          miscompares = 0;
    bit          mon_en = 1'b1;
    int          st_cnt = 0;
    int          we_cnt = 0;
    logic        mis_seen = 1'b0;
    logic [31:0] seen_wd = 32'h0;
    logic [31:0] seen_waddr = 32'h0;
    logic [31:0] last_rd = 32'h0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: accumulate per-transaction activity, compare on completion
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && lsu_req_i) begin
                if (mem_we_o) begin
                    we_cnt++;
                    seen_wd    = mem_wd_o;
                    seen_waddr = mem_addr_o;
                end
                if (lsu_misalign_o) mis_seen = 1'b1;
                if (lsu_stall_o) begin
                    st_cnt++;
                end else begin
                    if (sb_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL completion: got unexpected completion, expected none");
                    end else begin
                        mon_e = sb_q.pop_front();
                        check32("rd", lsu_rd_o, mon_e.rd);
                        check32("stall_cycles", 32'(st_cnt), 32'(mon_e.stalls));
                        check32("write_cycles", 32'(we_cnt), 32'(mon_e.writes));
                        check32("misalign", {31'h0, mis_seen}, {31'h0, mon_e.mis});
                        if (mon_e.writes > 0) begin
                            check32("mem_wd", seen_wd, mon_e.wd);
                            check32("mem_addr", seen_waddr, mon_e.waddr);
                        end
                    end
                    st_cnt   = 0;
                    we_cnt   = 0;
                    mis_seen = 1'b0;
                end
            end
        end
    end

    task automatic op(input logic we, input logic [2:0] size, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] erd, input logic [31:0] ewd,
                      input logic [31:0] ewaddr, input int stalls, input int writes,
                      input logic mis);
        exp_t e;
        logic done;
        e.rd = erd; e.wd = ewd; e.waddr = ewaddr;
        e.stalls = stalls; e.writes = writes; e.mis = mis;
        sb_q.push_back(e);
        @(posedge clk); #1;
        lsu_req_i = 1'b1; lsu_we_i = we; lsu_size_i = size;
        lsu_addr_i = addr; lsu_wd_i = wd;
        done = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge clk);
            if (!lsu_stall_o) done = 1'b1;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: got stall stuck high, expected release within 8 cycles");
        end
        @(posedge clk); #1;
        lsu_req_i = 1'b0;
    endtask

    task automatic ld(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] exp_rd);
        last_rd = exp_rd;
        op(1'b0, size, addr, 32'h0, exp_rd, 32'h0, 32'h0, 1, 0, 1'b0);
    endtask

    task automatic st(input logic [2:0] size, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_word, input logic [31:0] exp_waddr);
        op(1'b1, size, addr, wd, last_rd, exp_word, exp_waddr, 2, 1, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst_n = 1'b0; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 3'b000;
        lsu_addr_i = 32'h0; lsu_wd_i = 32'h0;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check32("reset_rd", lsu_rd_o, 32'h0);
        check32("reset_stall", {31'h0, lsu_stall_o}, 32'h0);
        check32("reset_misalign", {31'h0, lsu_misalign_o}, 32'h0);
        check32("reset_we", {31'h0, mem_we_o}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Word store / load
        st(SZ_W, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 32'h10);
        ld(SZ_W, 32'h10, 32'hDEADBEEF);
        // Byte store and signed/unsigned byte loads
        st(SZ_B, 32'h13, 32'hAAAAAA80, 32'h80ADBEEF, 32'h10);
        ld(SZ_B, 32'h13, 32'hFFFFFF80);
        ld(SZ_BU, 32'h13, 32'h00000080);
        // Halfword stores and loads
        st(SZ_H, 32'h12, 32'h55551234, 32'h1234BEEF, 32'h10);
        ld(SZ_H, 32'h12, 32'h00001234);
        ld(SZ_HU, 32'h12, 32'h00001234);
        st(SZ_H, 32'h12, 32'h00008001, 32'h8001BEEF, 32'h10);
        ld(SZ_H, 32'h12, 32'hFFFF8001);
        ld(SZ_HU, 32'h12, 32'h00008001);
        // Low lanes and undefined size code (acts as W)
        ld(SZ_B, 32'h10, 32'hFFFFFFEF);
        ld(SZ_BU, 32'h11, 32'h000000BE);
        ld(SZ_H, 32'h10, 32'hFFFFBEEF);
        ld(3'b011, 32'h10, 32'h8001BEEF);

        // Misaligned word load
`ifdef LSU_MISALIGN_TRAP_EN
        op(1'b0, SZ_W, 32'h11, 32'h0, last_rd, 32'h0, 32'h0, 0, 0, 1'b1);
`else
        ld(SZ_W, 32'h11, 32'h8001BEEF);
`endif

        // Reset asserted during the WRITE cycle of a store
        mon_en = 1'b0;
        @(posedge clk); #1;
        lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_size_i = SZ_W;
        lsu_addr_i = 32'h10; lsu_wd_i = 32'h11111111;
        @(negedge clk);
        check32("rstw_idle_stall", {31'h0, lsu_stall_o}, 32'h1);
        @(posedge clk); #1;
        rst_n = 1'b0; lsu_req_i = 1'b0;
        @(negedge clk);
        check32("rstw_we", {31'h0, mem_we_o}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check32("rstw_mem", mem[4], 32'h8001BEEF);
        check32("rstw_stall", {31'h0, lsu_stall_o}, 32'h0);
        check32("rstw_rd", lsu_rd_o, 32'h0);
        check32("rstw_we_after", {31'h0, mem_we_o}, 32'h0);
        last_rd = 32'h0;
        mon_en = 1'b1;

        // Address wrap modulo memory size
        st(SZ_W, 32'h404, 32'hCAFEF00D, 32'hCAFEF00D, 32'h004);
        @(negedge clk);
        check32("wrap_mem", mem[1], 32'hCAFEF00D);
        ld(SZ_W, 32'h004, 32'hCAFEF00D);
        ld(SZ_W, 32'h810, 32'h8001BEEF);

        repeat (2) @(posedge clk);
        check32("scoreboard_empty", 32'(sb_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
